ctl_cmd_unpacker: RTL

- Sits between the compute command FIFO (written by the host over AXI-Lite MMIO) and the mmult kernel start logic.
- Pops 32-bit command words and validates the size header and the matrix dimensions.
- Unpacks one command into a registered parameter bundle and presents it over a valid/ready handshake.
- Malformed commands are dropped and flagged, so the kernel only ever sees well-formed jobs.

---
 rtl/ctl_cmd_pkg.sv | 29 ++
 rtl/ctl_cmd_unpacker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ctl_cmd_pkg.sv
// Shared types and constants for the compute command unpacker.
package ctl_cmd_pkg;

  localparam int unsigned CMD_WORDS = 6;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned HALF_W    = 16;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SIZE     = 2'd1;
  localparam logic [1:0] ERR_ZERO_DIM = 2'd2;

  typedef enum logic [1:0] {
    HDR,
    BODY,
    DISCARD,
    EMIT
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] a_baseaddr;
    logic [WORD_W-1:0] b_baseaddr;
    logic [WORD_W-1:0] c_baseaddr;
    logic [HALF_W-1:0] a_row;
    logic [HALF_W-1:0] a_col;
    logic [HALF_W-1:0] b_col;
    logic [HALF_W-1:0] work_id;
  } ctl_cmd_t;

endpackage

// File: rtl/ctl_cmd_unpacker.sv
// Pops command words from the MMIO command FIFO, validates them and presents
// one well-formed mmult job at a time over a valid/ready handshake.
module ctl_cmd_unpacker
  import ctl_cmd_pkg::*;
#(
  parameter int unsigned MAX_CMD_WORDS = 16,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 axis_aclk,
  input  logic                 axis_arst,
  input  logic [31:0]          ctl_cmd_fifo_dout,
  input  logic                 ctl_cmd_fifo_empty_n,
  output logic                 ctl_cmd_fifo_rd_en,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [63:0]          a_baseaddr,
  output logic [63:0]          b_baseaddr,
  output logic [63:0]          c_baseaddr,
  output logic [31:0]          a_row,
  output logic [31:0]          a_col,
  output logic [31:0]          b_col,
  output logic [31:0]          work_id,
  output logic                 cmd_err,
  output logic [1:0]           cmd_err_code,
  output logic [CNT_WIDTH-1:0] cmd_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(MAX_CMD_WORDS + 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] size;
  logic             drop;
  ctl_cmd_t         shadow;
  ctl_cmd_t         shadow_nxt;
  ctl_cmd_t         out_q;

  logic pop;
  logic hdr_ok;
  logic last_body;
  logic dim_zero;
  logic disc_done;

  // Pop whenever data is present, except while a bundle is on offer.
  assign ctl_cmd_fifo_rd_en = ctl_cmd_fifo_empty_n && (state != EMIT) && !axis_arst;
  assign pop                = ctl_cmd_fifo_rd_en;
  assign busy               = (state != HDR);

  assign hdr_ok    = (ctl_cmd_fifo_dout >= 32'(CMD_WORDS)) &&
                     (ctl_cmd_fifo_dout <= 32'(MAX_CMD_WORDS));
  assign last_body = (idx == IDX_W'(CMD_WORDS - 1));
  // b_col comes straight off the FIFO head since w5 is being popped now.
  assign dim_zero  = (shadow.a_row == '0) || (shadow.a_col == '0) ||
                     (ctl_cmd_fifo_dout[HALF_W-1:0] == '0);
  assign disc_done = (idx == size - IDX_W'(1));

  assign a_baseaddr = 64'(out_q.a_baseaddr);
  assign b_baseaddr = 64'(out_q.b_baseaddr);
  assign c_baseaddr = 64'(out_q.c_baseaddr);
  assign a_row      = 32'(out_q.a_row);
  assign a_col      = 32'(out_q.a_col);
  assign b_col      = 32'(out_q.b_col);
  assign work_id    = 32'(out_q.work_id);

  // Shadow field capture, including the word popped this cycle.
  always_comb begin
    shadow_nxt = shadow;
    if (pop && (state == BODY)) begin
      case (32'(idx))
        1: shadow_nxt.a_baseaddr = ctl_cmd_fifo_dout;
        2: shadow_nxt.b_baseaddr = ctl_cmd_fifo_dout;
        3: shadow_nxt.c_baseaddr = ctl_cmd_fifo_dout;
        4: begin
          shadow_nxt.a_row = ctl_cmd_fifo_dout[HALF_W-1:0];
          shadow_nxt.a_col = ctl_cmd_fifo_dout[WORD_W-1:HALF_W];
        end
        5: begin
          shadow_nxt.b_col   = ctl_cmd_fifo_dout[HALF_W-1:0];
          shadow_nxt.work_id = ctl_cmd_fifo_dout[WORD_W-1:HALF_W];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_arst) begin
    if (axis_arst) begin
      state        <= HDR;
      idx          <= '0;
      size         <= '0;
      drop         <= 1'b0;
      shadow       <= '0;
      out_q        <= '0;
      cmd_valid    <= 1'b0;
      cmd_err      <= 1'b0;
      cmd_err_code <= ERR_NONE;
      cmd_count    <= '0;
      err_count    <= '0;
    end else begin
      cmd_err <= 1'b0;
      shadow  <= shadow_nxt;
      case (state)
        HDR: begin
          if (pop) begin
            if (hdr_ok) begin
              size  <= IDX_W'(ctl_cmd_fifo_dout);
              idx   <= IDX_W'(1);
              state <= BODY;
            end else begin
              cmd_err      <= 1'b1;
              cmd_err_code <= ERR_SIZE;
              err_count    <= err_count + CNT_WIDTH'(1);
            end
          end
        end
        BODY: begin
          if (pop) begin
            idx <= idx + IDX_W'(1);
            if (last_body) begin
              drop <= dim_zero;
              if (dim_zero) begin
                cmd_err      <= 1'b1;
                cmd_err_code <= ERR_ZERO_DIM;
                err_count    <= err_count + CNT_WIDTH'(1);
              end
              if (size > IDX_W'(CMD_WORDS)) begin
                state <= DISCARD;
              end else if (dim_zero) begin
                state <= HDR;
              end else begin
                out_q     <= shadow_nxt;
                cmd_valid <= 1'b1;
                state     <= EMIT;
              end
            end
          end
        end
        DISCARD: begin
          if (pop) begin
            idx <= idx + IDX_W'(1);
            if (disc_done) begin
              if (drop) begin
                state <= HDR;
              end else begin
                out_q     <= shadow_nxt;
                cmd_valid <= 1'b1;
                state     <= EMIT;
              end
            end
          end
        end
        EMIT: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_count <= cmd_count + CNT_WIDTH'(1);
            state     <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule
